pc_exception_sequencer: RTL

Multicycle sequencer for the PC/EPC datapath. It takes exception pulses from the main control unit and walks the datapath through the exception entry. It saves the return address into EPC, fetches the handler address byte from the fixed vector location (253/254/255), and loads it into PC through the PCSource mux. It also drives the return-from-exception path (EPC → PC) and reports busy/cause status so the control unit can stall instruction sequencing while it owns the PC.

---
 rtl/pc_exception_sequencer_if.sv | 23 ++
 rtl/pc_exception_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pc_exception_sequencer_if.sv
// Vector-fetch memory port between the exception sequencer (master) and memory (slave).
// Handshake: mem_req stays high with mem_addr held stable until the cycle in which the
// slave raises mem_ack; mem_rdata is valid in that same cycle and the transfer ends there.
interface pc_exception_sequencer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/pc_exception_sequencer.sv
// Exception entry / return sequencer for the PC/EPC datapath.
// Optional misaligned-PC exception source enabled by defining PC_MISALIGN_EN.
module pc_exception_sequencer #(
    parameter logic [31:0] VEC_OPCODE   = 32'd253,
    parameter logic [31:0] VEC_OVF      = 32'd254,
    parameter logic [31:0] VEC_DIV0     = 32'd255,
    parameter logic [31:0] VEC_MISALIGN = 32'd252
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            exc_opcode,
    input  logic                            exc_ovf,
    input  logic                            exc_div0,
    input  logic                            rfe,
    input  logic [31:0]                     pc_in,
    input  logic [31:0]                     pc_next,
`ifdef PC_MISALIGN_EN
    input  logic                            exc_misalign_chk,
`endif
    pc_exception_sequencer_if.master        mem,
    output logic                            epc_we,
    output logic [31:0]                     epc_wdata,
    output logic                            pc_we,
    output logic [2:0]                      pc_src,
    output logic [1:0]                      cause_sel,
    output logic [7:0]                      pc_vec_byte,
    output logic                            busy,
    output logic                            in_handler,
    output logic                            lost_exc,
    output logic [2:0]                      fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAVE    = 3'd1,
        S_REQ     = 3'd2,
        S_LOAD_PC = 3'd3,
        S_RETURN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [7:0]  byte_q, byte_d;
    logic        inh_q, inh_d;
    logic        lost_q, lost_d;

    logic        misalign_hit;
    logic        exc_any;
    logic [1:0]  exc_code;
    logic [31:0] vec_addr;

`ifdef PC_MISALIGN_EN
    logic unused_pc_next;
    assign misalign_hit   = exc_misalign_chk && (pc_next[1:0] != 2'b00);
    assign unused_pc_next = ^pc_next[31:2];
`else
    logic unused_pc_next;
    assign misalign_hit   = 1'b0;
    assign unused_pc_next = ^pc_next;
`endif

    assign exc_any = exc_opcode | exc_ovf | exc_div0 | misalign_hit;

    always_comb begin
        exc_code = 2'd3;
        if (exc_opcode)    exc_code = 2'd0;
        else if (exc_ovf)  exc_code = 2'd1;
        else if (exc_div0) exc_code = 2'd2;
    end

    always_comb begin
        vec_addr = VEC_MISALIGN;
        case (cause_q)
            2'd0:    vec_addr = VEC_OPCODE;
            2'd1:    vec_addr = VEC_OVF;
            2'd2:    vec_addr = VEC_DIV0;
            default: vec_addr = VEC_MISALIGN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cause_q <= 2'd0;
            byte_q  <= 8'd0;
            inh_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            byte_q  <= byte_d;
            inh_q   <= inh_d;
            lost_q  <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        byte_d  = byte_q;
        inh_d   = inh_q;
        lost_d  = lost_q;

        // A handler is already running, so any new exception would nest: record it as lost.
        if (state_q != S_IDLE && exc_any && inh_q) lost_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (exc_any) begin
                    if (inh_q) begin
                        lost_d = 1'b1;
                    end else begin
                        cause_d = exc_code;
                        state_d = S_SAVE;
                    end
                end else if (rfe && inh_q) begin
                    state_d = S_RETURN;
                end
            end
            S_SAVE: state_d = S_REQ;
            S_REQ: begin
                if (mem.mem_ack) begin
                    byte_d  = mem.mem_rdata;
                    inh_d   = 1'b1;
                    state_d = S_LOAD_PC;
                end
            end
            S_LOAD_PC: state_d = S_IDLE;
            S_RETURN: begin
                // Leaving the handler clears the sticky flag even if a pulse lands here.
                inh_d   = 1'b0;
                lost_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign epc_we       = (state_q == S_SAVE);
    assign epc_wdata    = pc_in - 32'd4;
    assign mem.mem_req  = (state_q == S_REQ);
    assign mem.mem_addr = (state_q == S_REQ) ? vec_addr : 32'd0;
    assign pc_we        = (state_q == S_LOAD_PC) || (state_q == S_RETURN);
    assign pc_src       = (state_q == S_LOAD_PC) ? 3'd3 :
                          (state_q == S_RETURN)  ? 3'd4 : 3'd0;
    assign cause_sel    = cause_q;
    assign pc_vec_byte  = byte_q;
    assign in_handler   = inh_q;
    assign lost_exc     = lost_q;
    assign fsm_state    = state_q;

endmodule
